// File: rtl/wb_byte_ram.sv
// Wishbone pipelined byte-lane RAM with fixed-latency ack that zero-fills itself after every reset.
// Optional: define WB_BYTE_RAM_BOUNDS_CHECK_EN to error-complete requests whose address exceeds the depth.
module wb_byte_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic [3:0]  i_wb_sel,
  output logic [31:0] o_wb_data,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic        o_wb_err
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("wb_byte_ram: LATENCY must be in 1..4");
  end

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_nxt;
  logic                  clr_en;
  logic                  stall;

  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic                  accept;
  logic                  oob;
  logic                  wr_en;

  logic                  vld_p  [LATENCY];
  logic [31:0]           data_p [LATENCY];

  function automatic logic [31:0] lane_mask(input logic [31:0] word, input logic [3:0] sel);
    logic [31:0] m;
    for (int n = 0; n < 4; n++) m[8*n +: 8] = sel[n] ? word[8*n +: 8] : 8'h00;
    return m;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= S_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    clr_en      = 1'b0;
    stall       = 1'b1;
    case (state)
      S_CLEAR: begin
        clr_en      = 1'b1;
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == {ADDR_WIDTH{1'b1}}) state_nxt = S_READY;
      end
      S_READY: stall = 1'b0;
      default: state_nxt = S_CLEAR;
    endcase
  end

  assign o_wb_stall = stall;
  assign idx        = i_wb_addr[ADDR_WIDTH-1:0];
  assign accept     = i_wb_stb && !stall && !i_reset;
  assign wr_en      = accept && i_wb_we && !oob;

`ifdef WB_BYTE_RAM_BOUNDS_CHECK_EN
  logic err_p [LATENCY];

  assign oob = |i_wb_addr[31:ADDR_WIDTH];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < LATENCY; i++) err_p[i] <= 1'b0;
    end else begin
      err_p[0] <= accept && oob;
      for (int i = 1; i < LATENCY; i++) err_p[i] <= err_p[i-1];
    end
  end

  assign o_wb_err = err_p[LATENCY-1];
`else
  // Upper address bits are deliberately ignored: addresses alias modulo the depth.
  logic unused_addr_hi;
  assign unused_addr_hi = ^i_wb_addr[31:ADDR_WIDTH];
  assign oob            = 1'b0;
  assign o_wb_err       = 1'b0;
`endif

  // Memory: the clear sequencer and request writes never overlap since stall covers the clear.
  always_ff @(posedge i_clk) begin
    if (clr_en) begin
      mem[clr_cnt] <= '0;
    end else if (wr_en) begin
      for (int n = 0; n < 4; n++)
        if (i_wb_sel[n]) mem[idx][8*n +: 8] <= i_wb_data[8*n +: 8];
    end
  end

  // Stage 0: read word sampled at the acceptance edge; later stages just delay it.
  always_ff @(posedge i_clk) begin
    data_p[0] <= (accept && !i_wb_we && !oob) ? lane_mask(mem[idx], i_wb_sel) : '0;
    for (int i = 1; i < LATENCY; i++) data_p[i] <= data_p[i-1];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < LATENCY; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= accept && !oob;
      for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Final stage: data is gated so the bus sees zero whenever no ack is presented.
  assign o_wb_ack  = vld_p[LATENCY-1];
  assign o_wb_data = vld_p[LATENCY-1] ? data_p[LATENCY-1] : '0;

endmodule
